// File: rtl/bram_sdp_pipe.sv
`default_nettype none
// ============================================================================
// Module      : bram_sdp_pipe
// Description : Simple-dual-port block RAM with a single clock. Port A writes
//               with per-lane enables. Port B reads through a 1- or 2-stage
//               pipeline and flags each new result with doutb_valid. Same-
//               address collisions return either the old word or the merged
//               new word. An optional sequencer zeroes the whole array after
//               reset, and the ports are ignored while it runs.
// Ports       : clk, rst           - clock / synchronous active-high reset
//               wea, addra, dina   - write port (per-lane enable)
//               enb, addrb         - read request
//               doutb, doutb_valid - read result and one-cycle valid pulse
//               init_busy          - clear sequencer running
// Revision    : 1.0 - initial release
// ============================================================================
module bram_sdp_pipe #(
  parameter int ADDR_WIDTH     = 11,
  parameter int DATA_WIDTH     = 32,
  parameter int LANE_WIDTH     = 8,
  parameter int READ_LATENCY   = 1,
  parameter int WRITE_FIRST    = 0,
  parameter int CLEAR_ON_RESET = 1,
  localparam int C_NUM_LANES   = DATA_WIDTH / LANE_WIDTH,
  localparam int C_DEPTH       = 1 << ADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [C_NUM_LANES-1:0] wea,
  input  logic [ADDR_WIDTH-1:0]  addra,
  input  logic [DATA_WIDTH-1:0]  dina,
  input  logic                   enb,
  input  logic [ADDR_WIDTH-1:0]  addrb,
  output logic [DATA_WIDTH-1:0]  doutb,
  output logic                   doutb_valid,
  output logic                   init_busy
);

  logic [DATA_WIDTH-1:0] r_mem [C_DEPTH];

  logic                  w_busy;
  logic                  w_clr_we;
  logic [ADDR_WIDTH-1:0] w_clr_addr;
  logic                  w_port_ok;
  logic                  w_rd_acc;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic                  w_out_vld;
  logic [DATA_WIDTH-1:0] w_out_data;
  logic [DATA_WIDTH-1:0] r_doutb;
  logic                  r_doutb_valid;

  // User ports are dead while resetting or clearing.
  assign w_port_ok = ~w_busy & ~rst;
  assign w_rd_acc  = enb & w_port_ok;

  // --------------------------------------------------------------------------
  // Clear sequencer
  // --------------------------------------------------------------------------
  if (CLEAR_ON_RESET != 0) begin : g_clear
    typedef enum logic [0:0] {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

    // One extra counter bit so the terminal count never aliases address 0.
    localparam logic [ADDR_WIDTH:0] C_LAST = (ADDR_WIDTH+1)'(C_DEPTH - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_WIDTH:0] r_cnt;
    logic [ADDR_WIDTH:0] w_cnt_nxt;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_state <= S_CLEAR;
        r_cnt   <= '0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
      end
    end

    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_clr_we    = 1'b0;
      if (r_state == S_CLEAR && !rst) begin
        w_clr_we  = 1'b1;
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == C_LAST) begin
          w_state_nxt = S_IDLE;
        end
      end
    end

    assign w_busy     = (r_state == S_CLEAR);
    assign w_clr_addr = r_cnt[ADDR_WIDTH-1:0];
  end else begin : g_no_clear
    assign w_busy     = 1'b0;
    assign w_clr_we   = 1'b0;
    assign w_clr_addr = '0;
  end

  // --------------------------------------------------------------------------
  // Memory array (contents are never reset directly)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[w_clr_addr] <= '0;
    end else if (w_port_ok) begin
      for (int i = 0; i < C_NUM_LANES; i++) begin
        if (wea[i]) begin
          r_mem[addra][i*LANE_WIDTH +: LANE_WIDTH] <= dina[i*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end
  end

  // Read word as seen at this edge; in write-first mode the lanes being
  // written to the same address are forwarded from dina.
  always_comb begin
    w_rd_word = r_mem[addrb];
    if (WRITE_FIRST != 0 && w_port_ok && addra == addrb) begin
      for (int i = 0; i < C_NUM_LANES; i++) begin
        if (wea[i]) begin
          w_rd_word[i*LANE_WIDTH +: LANE_WIDTH] = dina[i*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read pipeline
  // --------------------------------------------------------------------------
  if (READ_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] r_p1_data;
    logic                  r_p1_vld;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_p1_data <= '0;
        r_p1_vld  <= 1'b0;
      end else begin
        r_p1_vld <= w_rd_acc;
        if (w_rd_acc) begin
          r_p1_data <= w_rd_word;
        end
      end
    end

    assign w_out_vld  = r_p1_vld;
    assign w_out_data = r_p1_data;
  end else begin : g_lat1
    assign w_out_vld  = w_rd_acc;
    assign w_out_data = w_rd_word;
  end

  // Output register holds the last result between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_doutb       <= '0;
      r_doutb_valid <= 1'b0;
    end else begin
      r_doutb_valid <= w_out_vld;
      if (w_out_vld) begin
        r_doutb <= w_out_data;
      end
    end
  end

  assign doutb       = r_doutb;
  assign doutb_valid = r_doutb_valid;
  assign init_busy   = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_bram_sdp_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_bram_sdp_pipe
// Description : Self-checking bench for bram_sdp_pipe. It uses three instances
//               that share one set of stimulus:
//                 A: 16 words, latency 1, read-old,  clear on reset
//                 B: 16 words, latency 2, write-first, clear on reset
//                 C: 16 words, latency 1, read-old,  no clear
//               The reference model is a word array plus queues of pending
//               read results. Each queue entry records when the result is due.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_sdp_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  wea = '0;
  logic [3:0]  addra = '0;
  logic [31:0] dina = '0;
  logic        enb = 1'b0;
  logic [3:0]  addrb = '0;

  logic [31:0] a_dout, b_dout, c_dout;
  logic        a_vld, b_vld, c_vld;
  logic        a_busy, b_busy, c_busy;

  always #5 clk = ~clk;

  bram_sdp_pipe #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .LANE_WIDTH(8), .READ_LATENCY(1),
                  .WRITE_FIRST(0), .CLEAR_ON_RESET(1)) u_dut_a (
    .clk(clk), .rst(rst), .wea(wea), .addra(addra), .dina(dina), .enb(enb), .addrb(addrb),
    .doutb(a_dout), .doutb_valid(a_vld), .init_busy(a_busy));

  bram_sdp_pipe #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .LANE_WIDTH(8), .READ_LATENCY(2),
                  .WRITE_FIRST(1), .CLEAR_ON_RESET(1)) u_dut_b (
    .clk(clk), .rst(rst), .wea(wea), .addra(addra), .dina(dina), .enb(enb), .addrb(addrb),
    .doutb(b_dout), .doutb_valid(b_vld), .init_busy(b_busy));

  bram_sdp_pipe #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .LANE_WIDTH(8), .READ_LATENCY(1),
                  .WRITE_FIRST(0), .CLEAR_ON_RESET(0)) u_dut_c (
    .clk(clk), .rst(rst), .wea(wea), .addra(addra), .dina(dina), .enb(enb), .addrb(addrb),
    .doutb(c_dout), .doutb_valid(c_vld), .init_busy(c_busy));

  typedef struct {
    logic [3:0]  we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic        re;
    logic [3:0]  ra;
  } stim_t;

  typedef struct {
    int          due;
    logic [31:0] d;
  } rd_t;

  // ---------------- reference model ----------------
  logic [31:0] m_mem [16];   // contents of A and B
  logic [31:0] c_mem [16];   // contents of C (never cleared)
  int          clr_left = 0; // clear cycles still owed by A/B
  int          edge_n   = 0;
  rd_t         qa[$], qb[$], qc[$];
  logic        ea_v, eb_v, ec_v, e_busy;
  logic [31:0] ea_d = '0, eb_d = '0, ec_d = '0;

  int total = 0;
  int bad   = 0;

  localparam stim_t IDLE = '{we: 4'h0, wa: 4'h0, wd: 32'h0, re: 1'b0, ra: 4'h0};

  // Drive one cycle of stimulus, advance one clock, and update the model's
  // expected outputs. The task returns 1 time unit after the edge.
  task automatic cycle(input logic r, input stim_t s);
    logic [31:0] old_w, mrg_w;
    rd_t         t;
    rst = r; wea = s.we; addra = s.wa; dina = s.wd; enb = s.re; addrb = s.ra;
    @(posedge clk);
    edge_n++;
    ea_v = 1'b0; eb_v = 1'b0; ec_v = 1'b0;
    if (r) begin
      clr_left = 16;
      qa.delete(); qb.delete(); qc.delete();
      ea_d = '0; eb_d = '0; ec_d = '0;
    end else begin
      if (s.re) qc.push_back('{due: edge_n, d: c_mem[s.ra]});
      for (int i = 0; i < 4; i++)
        if (s.we[i]) c_mem[s.wa][i*8 +: 8] = s.wd[i*8 +: 8];
      if (clr_left > 0) begin
        m_mem[16 - clr_left] = '0;
        clr_left--;
      end else begin
        old_w = m_mem[s.ra];
        mrg_w = old_w;
        for (int i = 0; i < 4; i++)
          if (s.we[i] && s.wa == s.ra) mrg_w[i*8 +: 8] = s.wd[i*8 +: 8];
        if (s.re) begin
          qa.push_back('{due: edge_n,     d: old_w});
          qb.push_back('{due: edge_n + 1, d: mrg_w});
        end
        for (int i = 0; i < 4; i++)
          if (s.we[i]) m_mem[s.wa][i*8 +: 8] = s.wd[i*8 +: 8];
      end
      if (qa.size() > 0 && qa[0].due == edge_n) begin t = qa.pop_front(); ea_v = 1'b1; ea_d = t.d; end
      if (qb.size() > 0 && qb[0].due == edge_n) begin t = qb.pop_front(); eb_v = 1'b1; eb_d = t.d; end
      if (qc.size() > 0 && qc[0].due == edge_n) begin t = qc.pop_front(); ec_v = 1'b1; ec_d = t.d; end
    end
    e_busy = (clr_left > 0);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      cycle(1'b1, IDLE);
      total++;
      if ({a_vld, a_dout, a_busy} !== {1'b0, 32'h0, 1'b1}) begin
        bad++; $display("FAIL reset_a: got v=%b d=%h busy=%b, want v=0 d=0 busy=1", a_vld, a_dout, a_busy);
      end
      total++;
      if ({b_vld, b_dout, b_busy} !== {1'b0, 32'h0, 1'b1}) begin
        bad++; $display("FAIL reset_b: got v=%b d=%h busy=%b, want v=0 d=0 busy=1", b_vld, b_dout, b_busy);
      end
      total++;
      if ({c_vld, c_dout, c_busy} !== {1'b0, 32'h0, 1'b0}) begin
        bad++; $display("FAIL reset_c: got v=%b d=%h busy=%b, want v=0 d=0 busy=0", c_vld, c_dout, c_busy);
      end
    end
  endtask

  task automatic test_clear();
    int    k = 0;
    stim_t s;
    // The clear must run for exactly 16 cycles, and port traffic is ignored.
    while (k < 40) begin
      s = '{we: 4'($urandom), wa: 4'($urandom), wd: $urandom, re: 1'b1, ra: 4'($urandom)};
      cycle(1'b0, s);
      k++;
      total++;
      if ({a_vld, a_busy} !== {ea_v, e_busy} || {b_vld, b_busy} !== {eb_v, e_busy}) begin
        bad++; $display("FAIL clear_run @%0d: got a v=%b busy=%b b v=%b busy=%b, want v=%b/%b busy=%b",
                        edge_n, a_vld, a_busy, b_vld, b_busy, ea_v, eb_v, e_busy);
      end
      if (!a_busy) break;
    end
    total++;
    if (k != 16) begin
      bad++; $display("FAIL clear_len: got %0d cycles, want 16", k);
    end
    // Every address must now read back as zero.
    for (int i = 0; i < 18; i++) begin
      s = IDLE;
      if (i < 16) begin s.re = 1'b1; s.ra = 4'(i); end
      cycle(1'b0, s);
      total++;
      if ({a_vld, a_dout} !== {ea_v, ea_d} || {b_vld, b_dout} !== {eb_v, eb_d} || a_dout !== 32'h0) begin
        bad++; $display("FAIL clear_zero @%0d: got a=%b/%h b=%b/%h, want a=%b/%h b=%b/%h",
                        edge_n, a_vld, a_dout, b_vld, b_dout, ea_v, ea_d, eb_v, eb_d);
      end
    end
  endtask

  task automatic test_write_read();
    stim_t st [4];
    st[0] = '{we: 4'hF, wa: 4'd5, wd: 32'hDEADBEEF, re: 1'b0, ra: 4'd0};
    st[1] = '{we: 4'h0, wa: 4'd0, wd: 32'h0,        re: 1'b1, ra: 4'd5};
    st[2] = IDLE;
    st[3] = IDLE;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, st[i]);
      total++;
      if ({a_vld, a_dout} !== {ea_v, ea_d} || {b_vld, b_dout} !== {eb_v, eb_d}) begin
        bad++; $display("FAIL wr_rd_model @%0d: got a=%b/%h b=%b/%h, want a=%b/%h b=%b/%h",
                        edge_n, a_vld, a_dout, b_vld, b_dout, ea_v, ea_d, eb_v, eb_d);
      end
      if (i == 1) begin
        total++;
        if ({a_vld, a_dout, c_vld, c_dout} !== {1'b1, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF}) begin
          bad++; $display("FAIL wr_rd_data: got a=%b/%h c=%b/%h, want 1/deadbeef both", a_vld, a_dout, c_vld, c_dout);
        end
      end
      if (i == 2) begin
        total++;
        if ({a_vld, a_dout} !== {1'b0, 32'hDEADBEEF}) begin
          bad++; $display("FAIL wr_rd_hold: got a=%b/%h, want 0/deadbeef", a_vld, a_dout);
        end
      end
    end
  endtask

  task automatic test_lanes();
    stim_t st [5];
    st[0] = '{we: 4'hF,    wa: 4'd7, wd: 32'h11223344, re: 1'b0, ra: 4'd0};
    st[1] = '{we: 4'b0101, wa: 4'd7, wd: 32'hAABBCCDD, re: 1'b0, ra: 4'd0};
    st[2] = '{we: 4'h0,    wa: 4'd0, wd: 32'h0,        re: 1'b1, ra: 4'd7};
    st[3] = IDLE;
    st[4] = IDLE;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, st[i]);
      total++;
      if ({a_vld, a_dout} !== {ea_v, ea_d} || {b_vld, b_dout} !== {eb_v, eb_d}) begin
        bad++; $display("FAIL lanes_model @%0d: got a=%b/%h b=%b/%h, want a=%b/%h b=%b/%h",
                        edge_n, a_vld, a_dout, b_vld, b_dout, ea_v, ea_d, eb_v, eb_d);
      end
      if (i == 2) begin
        total++;
        if ({a_vld, a_dout, c_dout} !== {1'b1, 32'h11BB33DD, 32'h11BB33DD}) begin
          bad++; $display("FAIL lanes_a: got a=%b/%h c=%h, want 1/11bb33dd", a_vld, a_dout, c_dout);
        end
      end
      if (i == 3) begin
        total++;
        if ({b_vld, b_dout} !== {1'b1, 32'h11BB33DD}) begin
          bad++; $display("FAIL lanes_b: got b=%b/%h, want 1/11bb33dd", b_vld, b_dout);
        end
      end
    end
  endtask

  task automatic test_collision();
    stim_t st [4];
    st[0] = '{we: 4'hF, wa: 4'd3, wd: 32'h0,  re: 1'b0, ra: 4'd0};
    st[1] = '{we: 4'hF, wa: 4'd3, wd: 32'h55, re: 1'b1, ra: 4'd3};
    st[2] = IDLE;
    st[3] = IDLE;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, st[i]);
      total++;
      if ({a_vld, a_dout} !== {ea_v, ea_d} || {b_vld, b_dout} !== {eb_v, eb_d}) begin
        bad++; $display("FAIL coll_model @%0d: got a=%b/%h b=%b/%h, want a=%b/%h b=%b/%h",
                        edge_n, a_vld, a_dout, b_vld, b_dout, ea_v, ea_d, eb_v, eb_d);
      end
      if (i == 1) begin
        total++;
        if ({a_vld, a_dout, c_dout} !== {1'b1, 32'h0, 32'h0}) begin
          bad++; $display("FAIL coll_read_first: got a=%b/%h c=%h, want 1/00000000", a_vld, a_dout, c_dout);
        end
      end
      if (i == 2) begin
        total++;
        if ({b_vld, b_dout} !== {1'b1, 32'h55}) begin
          bad++; $display("FAIL coll_write_first: got b=%b/%h, want 1/00000055", b_vld, b_dout);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t s;
    for (int i = 0; i < 10; i++) begin
      s = IDLE;
      if (i < 4) begin s.we = 4'hF; s.wa = 4'(i); s.wd = 32'hC0DE0000 + 32'(i); end
      else if (i < 8) begin s.re = 1'b1; s.ra = 4'(i - 4); end
      cycle(1'b0, s);
      total++;
      if ({a_vld, a_dout} !== {ea_v, ea_d} || {b_vld, b_dout} !== {eb_v, eb_d}) begin
        bad++; $display("FAIL b2b_model @%0d: got a=%b/%h b=%b/%h, want a=%b/%h b=%b/%h",
                        edge_n, a_vld, a_dout, b_vld, b_dout, ea_v, ea_d, eb_v, eb_d);
      end
      if (i >= 5 && i <= 8) begin
        total++;
        if ({b_vld, b_dout} !== {1'b1, 32'hC0DE0000 + 32'(i - 5)}) begin
          bad++; $display("FAIL b2b_lat2 step %0d: got b=%b/%h, want 1/%h", i, b_vld, b_dout, 32'hC0DE0000 + 32'(i - 5));
        end
      end
      if (i == 9) begin
        total++;
        if (b_vld !== 1'b0) begin
          bad++; $display("FAIL b2b_end: got b_vld=%b, want 0", b_vld);
        end
      end
    end
  endtask

  task automatic test_random();
    stim_t s;
    for (int i = 0; i < 400; i++) begin
      s.we = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      s.wa = 4'($urandom);
      s.wd = $urandom;
      s.re = 1'($urandom);
      // Bias toward collisions so both collision modes get exercised.
      s.ra = ($urandom_range(0, 3) == 0) ? s.wa : 4'($urandom);
      cycle(1'b0, s);
      total++;
      if ({a_vld, a_dout, a_busy} !== {ea_v, ea_d, e_busy} ||
          {b_vld, b_dout, b_busy} !== {eb_v, eb_d, e_busy} ||
          {c_vld, c_busy} !== {ec_v, 1'b0}) begin
        bad++; $display("FAIL random @%0d: got a=%b/%h b=%b/%h c=%b, want a=%b/%h b=%b/%h c=%b",
                        edge_n, a_vld, a_dout, b_vld, b_dout, c_vld, ea_v, ea_d, eb_v, eb_d, ec_v);
      end
    end
  endtask

  task automatic test_reset_midclear();
    int    k = 0;
    stim_t s;
    // Start a read, then reset before the latency-2 result can complete.
    s = '{we: 4'h0, wa: 4'd0, wd: 32'h0, re: 1'b1, ra: 4'd5};
    cycle(1'b0, s);
    cycle(1'b1, IDLE);
    total++;
    if ({a_vld, a_dout, b_vld, b_dout} !== {1'b0, 32'h0, 1'b0, 32'h0}) begin
      bad++; $display("FAIL rst_inflight: got a=%b/%h b=%b/%h, want 0/0 both", a_vld, a_dout, b_vld, b_dout);
    end
    // Let the clear reach count 8, then reset again.
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, IDLE);
      total++;
      if ({a_busy, b_busy} !== {e_busy, e_busy}) begin
        bad++; $display("FAIL midclear_busy @%0d: got %b%b, want %b", edge_n, a_busy, b_busy, e_busy);
      end
    end
    cycle(1'b1, IDLE);
    while (k < 40) begin
      s = '{we: 4'hF, wa: 4'($urandom), wd: $urandom, re: 1'b1, ra: 4'($urandom)};
      cycle(1'b0, s);
      k++;
      total++;
      if ({a_vld, a_busy, b_vld, b_busy} !== {ea_v, e_busy, eb_v, e_busy}) begin
        bad++; $display("FAIL reclear_run @%0d: got a=%b/%b b=%b/%b, want v=%b/%b busy=%b",
                        edge_n, a_vld, a_busy, b_vld, b_busy, ea_v, eb_v, e_busy);
      end
      if (!a_busy) break;
    end
    total++;
    if (k != 16) begin
      bad++; $display("FAIL reclear_len: got %0d cycles, want 16", k);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      m_mem[i] = 'x;
      c_mem[i] = 'x;
    end
    #2;
    test_reset();
    test_clear();
    test_write_read();
    test_lanes();
    test_collision();
    test_back_to_back();
    test_random();
    test_reset_midclear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
